// File: rtl/sram_mem_sequencer.sv
// Sequences one 32-bit MEM-stage access into two half-word cycles on a 16-bit async SRAM.
// Optional build macro: SRAM_POSTED_WRITE_EN (writes run in the background without freezing).
module sram_mem_sequencer #(
    parameter int unsigned WAIT_CYCLES = 3,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    input  logic [15:0] sram_dq_in,
    output logic        sram_dq_oe,
    output logic        sram_we_n
);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 1..15");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [31:0] wdata_q, wdata_d;
    logic        op_write_q, op_write_d;
    logic [31:0] read_data_q, read_data_d;

    logic [31:0] off;
    logic        req;
    logic        last;
    logic        hi;
    logic        unused_off_bits;

    assign off             = address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign req             = mem_read | mem_write;
    assign last            = (cnt_q == LAST_CNT);
    assign hi              = (state_q == S_HIGH);
    assign read_data       = read_data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            wdata_q     <= '0;
            op_write_q  <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            op_write_q  <= op_write_d;
            read_data_q <= read_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        wdata_d     = wdata_q;
        op_write_d  = op_write_q;
        read_data_d = read_data_q;
        ready       = 1'b0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        sram_addr   = {word_q, 1'b0};

        case (state_q)
            S_IDLE: begin
`ifdef SRAM_POSTED_WRITE_EN
                ready = mem_write | ~mem_read;
`else
                ready = ~req;
`endif
                if (req) begin
                    word_d     = off[18:2];
                    wdata_d    = write_data;
                    op_write_d = mem_write;
                    cnt_d      = '0;
                    state_d    = S_LOW;
                end
            end

            S_LOW, S_HIGH: begin
                sram_addr = {word_q, hi};
                if (op_write_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = hi ? wdata_q[31:16] : wdata_q[15:0];
`ifdef SRAM_POSTED_WRITE_EN
                    // Background write: only a new request has to wait.
                    ready = ~req;
`endif
                end else if (last) begin
                    if (hi) begin
                        read_data_d[31:16] = sram_dq_in;
                    end else begin
                        read_data_d[15:0] = sram_dq_in;
                    end
                end
                if (last) begin
                    cnt_d   = '0;
                    state_d = hi ? S_DONE : S_HIGH;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            S_DONE: begin
`ifdef SRAM_POSTED_WRITE_EN
                ready = op_write_q ? ~req : 1'b1;
`else
                ready = 1'b1;
`endif
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_sequencer.sv
// Randomized bench for sram_mem_sequencer: a half-word SRAM model on the pins and a
// reference store of expected SRAM contents derived from the transaction rules.
module tb_sram_mem_sequencer;

    localparam int          W    = 3;
    localparam logic [31:0] BASE = 32'd1024;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_we_n;

    logic [15:0] salt = 16'h0;
    logic [15:0] sram [0:255];
    bit          sram_written [0:255];
    logic [15:0] ref_half [0:255];
    logic [31:0] ref_rdata = '0;
    int          n_checks = 0;
    int          n_pass = 0;

    sram_mem_sequencer #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [7:0] a);
        return 16'({8'h0, a} * 16'h9E37) ^ salt;
    endfunction

    // Asynchronous SRAM: reads follow the address, writes land while we_n is low.
    assign sram_dq_in = sram_written[sram_addr[7:0]] ? sram[sram_addr[7:0]] : init_val(sram_addr[7:0]);
    always @(posedge clk) begin
        if (!sram_we_n) begin
            sram[sram_addr[7:0]]         <= sram_dq_out;
            sram_written[sram_addr[7:0]] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mem_read  = 1'b0;
            mem_write = 1'b0;
            #1;
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_we_n", 32'(sram_we_n), 32'd1);
            check("idle_oe", 32'(sram_dq_oe), 32'd0);
            check("idle_rdata", read_data, ref_rdata);
        end
    endtask

    // One full access starting in an IDLE cycle; expectations come from the cycle map
    // T0 request, T1..TW low half, TW+1..T2W high half, T2W+1 done.
    task automatic do_op(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit hold);
        logic [31:0] off;
        logic [16:0] word;
        logic [7:0]  lo_i, hi_i;
        logic [31:0] exp_rd;
        bit          keep;
        off  = addr - BASE;
        word = off[18:2];
        lo_i = 8'({word, 1'b0});
        hi_i = 8'({word, 1'b1});
        keep = hold && !(POSTED && wr);
        @(negedge clk);
        mem_write  = wr;
        mem_read   = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
        address    = addr;
        write_data = data;
        #1 check("t0_ready", 32'(ready), (POSTED && wr) ? 32'd1 : 32'd0);
        for (int k = 1; k <= 2 * W + 1; k++) begin
            @(negedge clk);
            address    = $urandom;
            write_data = $urandom;
            if (!keep) begin
                mem_read  = 1'b0;
                mem_write = 1'b0;
            end
            #1;
            if (k <= 2 * W) begin
                check("ph_addr", 32'(sram_addr), (k <= W) ? 32'({word, 1'b0}) : 32'({word, 1'b1}));
                check("ph_we_n", 32'(sram_we_n), 32'(!wr));
                check("ph_oe", 32'(sram_dq_oe), 32'(wr));
                if (wr) check("ph_dq", 32'(sram_dq_out), (k <= W) ? 32'(data[15:0]) : 32'(data[31:16]));
                check("ph_ready", 32'(ready), (POSTED && wr) ? 32'(!(mem_read || mem_write)) : 32'd0);
            end else begin
                check("done_ready", 32'(ready), 32'd1);
                check("done_we_n", 32'(sram_we_n), 32'd1);
                check("done_addr", 32'(sram_addr), 32'({word, 1'b0}));
                if (wr) begin
                    check("done_rdata_hold", read_data, ref_rdata);
                    ref_half[lo_i] = data[15:0];
                    ref_half[hi_i] = data[31:16];
                end else begin
                    exp_rd = {ref_half[hi_i], ref_half[lo_i]};
                    check("done_rdata", read_data, exp_rd);
                    ref_rdata = exp_rd;
                end
            end
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Reset lands in T4 of a write: low half is already in the SRAM, high half is not.
    task automatic reset_mid_write(input logic [16:0] word, input logic [31:0] data);
        @(negedge clk);
        mem_write  = 1'b1;
        address    = BASE + 32'(word) * 4;
        write_data = data;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            mem_write = 1'b0;
        end
        rst = 1'b1;
        #1;
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_oe", 32'(sram_dq_oe), 32'd0);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_rdata", read_data, 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        ref_half[8'({word, 1'b0})] = data[15:0];
        ref_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

`ifdef SRAM_POSTED_WRITE_EN
    task automatic posted_overlap(input logic [16:0] word, input logic [31:0] data);
        @(negedge clk);
        mem_write  = 1'b1;
        address    = BASE + 32'(word) * 4;
        write_data = data;
        #1 check("pw_t0_ready", 32'(ready), 32'd1);
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        mem_read = 1'b1;
        #1 check("pw_t2_ready", 32'(ready), 32'd0);
        for (int t = 3; t <= 8 + 2 * W + 1; t++) begin
            @(negedge clk);
            #1 check("pw_ready", 32'(ready), 32'(t == 8 + 2 * W + 1));
        end
        check("pw_rdata", read_data, data);
        ref_half[8'({word, 1'b0})] = data[15:0];
        ref_half[8'({word, 1'b1})] = data[31:16];
        ref_rdata = data;
        mem_read = 1'b0;
    endtask
`endif

    initial begin
        logic [16:0] word;
        logic [31:0] addr;
        salt = 16'($urandom);
        for (int i = 0; i < 256; i++) ref_half[i] = init_val(8'(i));
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_we_n", 32'(sram_we_n), 32'd1);
        check("reset_addr", 32'(sram_addr), 32'd0);
        check("reset_dq", 32'(sram_dq_out), 32'd0);
        check("reset_rdata", read_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(5);

        do_op(1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        do_op(1'b0, 32'd1028, 32'h0, 1'b0);
        do_op(1'b1, 32'd1036, 32'h12345678, 1'b1);
        do_op(1'b0, 32'd1036, 32'h0, 1'b1);
        idle_cycles(2);

        reset_mid_write(17'd5, 32'hCAFEF00D);
        do_op(1'b0, BASE + 32'd20, 32'h0, 1'b0);
        idle_cycles(1);

`ifdef SRAM_POSTED_WRITE_EN
        posted_overlap(17'd9, 32'hA5A55A5A);
        idle_cycles(1);
`endif

        for (int n = 0; n < 40; n++) begin
            word = 17'($urandom_range(0, 127));
            addr = BASE + 32'(word) * 4 + 32'($urandom_range(0, 3)) + (32'($urandom_range(0, 7)) << 19);
            do_op(1'($urandom_range(0, 1)), addr, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
